mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing the single 128-bit memory port between the instruction cache (read-only) and the data cache (read/write-back). It sits between both caches' `mem_*` interfaces and the external memory, serialises their transactions, and alternates grants round-robin on contention so neither side starves. Each cache sees the arbiter as a private memory with the same `read`/`write`/`ready` protocol.

## Interface
Parameters:
- `ADDR_W`, default 28, block address width (word address >> 2).
- `DATA_W`, default 128, line width.

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `proc_reset` input 1: reset, synchronous, active-high.
- `i_read` input 1: I-cache read request, held until `i_ready`.
- `i_addr` input ADDR_W: I-cache block address.
- `i_rdata` output DATA_W: line returned to I-cache.
- `i_ready` output 1: I-cache transaction complete, one-cycle pulse.
- `d_read` input 1: D-cache read request, held until `d_ready`.
- `d_write` input 1: D-cache write-back request, held until `d_ready`.
- `d_addr` input ADDR_W: D-cache block address.
- `d_wdata` input DATA_W: D-cache write-back line.
- `d_rdata` output DATA_W: line returned to D-cache.
- `d_ready` output 1: D-cache transaction complete, one-cycle pulse.
- `mem_read` output 1: memory read strobe, registered.
- `mem_write` output 1: memory write strobe, registered.
- `mem_addr` output ADDR_W: memory block address, registered.
- `mem_wdata` output DATA_W: memory write data, registered.
- `mem_rdata` input DATA_W: memory read data, valid while `mem_ready`=1.
- `mem_ready` input 1: memory transaction complete.

## Operation
- States: `IDLE`, `SERVE_I`, `SERVE_D`. Register `last_grant` (0=I, 1=D).
- `IDLE`, grant selection:
  - Only I requests: grant I.
  - Only D requests (`d_read|d_write`): grant D.
  - Both request: grant the side not equal to `last_grant`.
  - Neither requests: stay in `IDLE`.
- On a grant, the next edge moves to `SERVE_x`, updates `last_grant`, and latches the memory request.
  - I grant: `mem_read`=1, `mem_addr`=`i_addr`.
  - D grant: `mem_read`=`d_read & ~d_write`, `mem_write`=`d_write`, `mem_addr`=`d_addr`, `mem_wdata`=`d_wdata`.
  - `d_read` and `d_write` together is illegal; the write wins.
- `SERVE_x`: memory outputs hold their values. Requester inputs are not resampled.
  - When `mem_ready`=1: `x_ready`=1 combinationally in the same cycle.
  - Next edge: state goes to `IDLE`; `mem_read`, `mem_write`, `mem_addr`, `mem_wdata` clear to 0.
- `i_rdata` and `d_rdata` are both wired directly to `mem_rdata`. Only the granted side's ready qualifies the data.
- `mem_ready` while in `IDLE` is ignored: no ready pulse, no state change.
- The ungranted requester keeps its request asserted and waits. Its ready stays 0.

## Timing
- Reset values: state `IDLE`; `last_grant`=D, so the first tie goes to I. `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0. `i_ready`=0, `d_ready`=0.
- Request-to-memory latency: a request in `IDLE` cycle t gives memory strobe high from cycle t+1.
- Response-to-requester latency: `mem_ready` in cycle u gives `x_ready` and data in cycle u (zero latency).
- Strobe release: memory strobes drop at u+1, and the FSM is back in `IDLE` at u+1.
- Earliest next grant: evaluated in cycle u+1, so the memory strobe is re-asserted at u+2.
  - Minimum gap between back-to-back transactions is one idle memory cycle.
- Caches deassert their request on the same edge they consume ready. The `IDLE` cycle at u+1 therefore never re-grants a completed request.
- Reset mid-transaction: all state clears on the reset edge, and any in-flight memory response is dropped. Caches are reset by the same `proc_reset`.
- `mem_ready` asserted for more than one cycle: only the first cycle completes the transaction. Later cycles fall in `IDLE` and are ignored.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state encoding (`IDLE`=2'd0, `SERVE_I`=2'd1, `SERVE_D`=2'd2);
  - grant encoding constants `GNT_I`=1'b0, `GNT_D`=1'b1;
  - the default `ADDR_W`/`DATA_W` values.
- One sub-module, `rr_pick2`: combinational two-way round-robin picker.
  - Inputs: `req_i`, `req_d`, `last_grant`.
  - Outputs: `gnt_valid`, `gnt_sel`.
- Everything else lives in the top module: FSM, output registers, ready steering.

## Test plan
- Reset, then no requests for 10 cycles: all `mem_*` outputs 0, both readies 0, FSM stays `IDLE`.
- I read of 0x0000010, memory ready after 3 cycles with data 0xDEAD...F625:
  - `mem_read`=1 and `mem_addr`=0x0000010 one cycle after the request;
  - `i_ready` pulses together with `mem_ready`, with `i_rdata` equal to that data;
  - `mem_read`=0 the following cycle.
- D write-back of 0x00000A0 with `d_wdata`=128'h1234…: `mem_write`=1 with that address and data; `d_ready` on `mem_ready`; `i_ready` stays 0.
- I and D requests raised in the same cycle after reset:
  - I served first, then D served starting two cycles after I's `mem_ready`.
  - On repeated simultaneous requests, grants alternate D, I, D.
- `mem_ready` pulsed while `IDLE`: no ready output. Then `proc_reset` asserted during `SERVE_D`: the next cycle shows `IDLE`, `mem_write`=0, and no `d_ready` pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-way I/D cache memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServeI = 2'd1,
    StServeD = 2'd2
  } arb_state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on a tie, grant the side not served last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_sel
);

  always_comb begin
    gnt_valid = req_i | req_d;
    if (req_i && req_d) begin
      gnt_sel = (last_grant == GNT_D) ? GNT_I : GNT_D;
    end else begin
      gnt_sel = req_d ? GNT_D : GNT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache reads and D-cache read/write-backs onto one registered memory port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              gnt_valid, gnt_sel;

  rr_pick2 u_pick (
    .req_i     (i_read),
    .req_d     (d_read | d_write),
    .last_grant(last_grant_q),
    .gnt_valid (gnt_valid),
    .gnt_sel   (gnt_sel)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_ready      = 1'b0;
    d_ready      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          if (gnt_sel == GNT_D) begin
            state_d      = StServeD;
            last_grant_d = GNT_D;
            // A simultaneous read and write is illegal; the write-back takes priority.
            mem_read_d   = d_read & ~d_write;
            mem_write_d  = d_write;
            mem_addr_d   = d_addr;
            mem_wdata_d  = d_wdata;
          end else begin
            state_d      = StServeI;
            last_grant_d = GNT_I;
            mem_read_d   = 1'b1;
            mem_write_d  = 1'b0;
            mem_addr_d   = i_addr;
            mem_wdata_d  = '0;
          end
        end
      end
      StServeI, StServeD: begin
        i_ready = (state_q == StServeI) & mem_ready;
        d_ready = (state_q == StServeD) & mem_ready;
        if (mem_ready) begin
          state_d     = StIdle;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end
      default: begin
        state_d     = StIdle;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q      <= StIdle;
      last_grant_q <= GNT_D;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level arbiter model.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          i_read, d_read, d_write, mem_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_ready, d_ready, mem_read, mem_write;
  logic [AW-1:0] mem_addr;

  int checks   = 0;
  int failures = 0;

  // Model: who owns the port (0 none, 1 I, 2 D), who was granted last, and the issued request.
  int            m_owner;
  bit            m_last_d;
  logic          m_read, m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          e_i_ready, e_d_ready;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .proc_reset(proc_reset),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Sample mid-cycle and compare every output against the model.
  task automatic at_neg();
    @(negedge clk);
    e_i_ready = (m_owner == 1) && mem_ready;
    e_d_ready = (m_owner == 2) && mem_ready;
    chk("mem_read", 128'(mem_read), 128'(m_read));
    chk("mem_write", 128'(mem_write), 128'(m_write));
    chk("mem_addr", 128'(mem_addr), 128'(m_addr));
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("i_ready", 128'(i_ready), 128'(e_i_ready));
    chk("d_ready", 128'(d_ready), 128'(e_d_ready));
    chk("i_rdata", i_rdata, mem_rdata);
    chk("d_rdata", d_rdata, mem_rdata);
  endtask

  task automatic model_clear();
    m_owner = 0;
    m_read  = 1'b0;
    m_write = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
  endtask

  // Advance the model on the clock edge using the inputs held during the ending cycle.
  task automatic tick();
    bit ir, dr;
    @(posedge clk);
    ir = i_read;
    dr = d_read | d_write;
    if (proc_reset) begin
      model_clear();
      m_last_d = 1'b1;
    end else if (m_owner == 0) begin
      if (ir && (!dr || m_last_d)) begin
        m_owner  = 1;
        m_last_d = 1'b0;
        m_read   = 1'b1;
        m_write  = 1'b0;
        m_addr   = i_addr;
        m_wdata  = '0;
      end else if (dr) begin
        m_owner  = 2;
        m_last_d = 1'b1;
        m_read   = d_read & ~d_write;
        m_write  = d_write;
        m_addr   = d_addr;
        m_wdata  = d_wdata;
      end
    end else if (mem_ready) begin
      model_clear();
    end
    #1;
  endtask

  task automatic cyc();
    at_neg();
    tick();
  endtask

  initial begin
    logic [DW-1:0] rd_data;
    int i_cool, d_cool;
    proc_reset = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ready = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    model_clear();
    m_last_d = 1'b1;
    repeat (2) tick();
    proc_reset = 1'b0;

    // Quiet after reset.
    for (int k = 0; k < 10; k++) begin
      at_neg();
      chk("idle_state", 128'(dut.state_q), 128'(0));
      chk("idle_mem_read", 128'(mem_read), 128'(0));
      tick();
    end

    // I read with a 3-cycle memory latency.
    rd_data = 128'hDEADBEEF_01234567_89ABCDEF_0BADF625;
    i_read = 1'b1; i_addr = 28'h0000010;
    cyc();
    at_neg();
    chk("i_strobe", 128'(mem_read), 128'(1));
    chk("i_addr", 128'(mem_addr), 128'h10);
    tick();
    cyc(); cyc();
    mem_ready = 1'b1; mem_rdata = rd_data;
    at_neg();
    chk("i_ready_pulse", 128'(i_ready), 128'(1));
    chk("i_rdata_val", i_rdata, rd_data);
    tick();
    i_read = 1'b0; mem_ready = 1'b0;
    at_neg();
    chk("i_release", 128'(mem_read), 128'(0));
    tick();

    // D write-back.
    d_write = 1'b1; d_addr = 28'h00000A0;
    d_wdata = 128'h12345678_9ABCDEF0_11223344_55667788;
    cyc();
    at_neg();
    chk("d_wstrobe", 128'(mem_write), 128'(1));
    chk("d_waddr", 128'(mem_addr), 128'hA0);
    chk("d_wdata", mem_wdata, 128'h12345678_9ABCDEF0_11223344_55667788);
    tick();
    mem_ready = 1'b1;
    at_neg();
    chk("d_ready_pulse", 128'(d_ready), 128'(1));
    chk("d_no_i_ready", 128'(i_ready), 128'(0));
    tick();
    d_write = 1'b0; mem_ready = 1'b0;
    cyc();

    // Ties after reset: I first, then alternating, with a one-cycle idle gap.
    proc_reset = 1'b1; cyc(); proc_reset = 1'b0;
    i_read = 1'b1; i_addr = 28'h0000123;
    d_read = 1'b1; d_addr = 28'h0000456;
    cyc();
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("tie_strobe", 128'(mem_read), 128'(1));
      chk("tie_addr", 128'(mem_addr), (k % 2 == 0) ? 128'h123 : 128'h456);
      tick();
      mem_ready = 1'b1;
      at_neg();
      chk("tie_i_ready", 128'(i_ready), 128'((k % 2) == 0));
      chk("tie_d_ready", 128'(d_ready), 128'((k % 2) == 1));
      tick();
      mem_ready = 1'b0;
      if (k % 2 == 0) i_read = 1'b0;
      else d_read = 1'b0;
      at_neg();
      chk("gap_idle", 128'(mem_read), 128'(0));
      tick();
      if (k % 2 == 0) i_read = 1'b1;
      else d_read = 1'b1;
    end
    i_read = 1'b0; d_read = 1'b0;
    proc_reset = 1'b1; cyc(); proc_reset = 1'b0;

    // Stray mem_ready while idle is ignored.
    mem_ready = 1'b1;
    repeat (3) begin
      at_neg();
      chk("stray_i_ready", 128'(i_ready), 128'(0));
      chk("stray_d_ready", 128'(d_ready), 128'(0));
      tick();
    end
    mem_ready = 1'b0;

    // Reset in the middle of a D transaction drops it.
    d_write = 1'b1; d_addr = 28'h0000BEE; d_wdata = rand128();
    cyc();
    proc_reset = 1'b1;
    at_neg();
    chk("mid_wstrobe", 128'(mem_write), 128'(1));
    tick();
    proc_reset = 1'b0; d_write = 1'b0; mem_ready = 1'b1;
    at_neg();
    chk("rst_state", 128'(dut.state_q), 128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_d_ready", 128'(d_ready), 128'(0));
    tick();
    mem_ready = 1'b0;

    // Randomized traffic: caches hold requests until ready and drop them on that edge.
    i_cool = 0;
    d_cool = 0;
    for (int c = 0; c < 800; c++) begin
      int r;
      mem_ready  = ($urandom_range(0, 2) == 0);
      mem_rdata  = rand128();
      proc_reset = ($urandom_range(0, 99) == 0);
      if (!i_read && i_cool == 0 && $urandom_range(0, 2) == 0) begin
        i_read = 1'b1;
        i_addr = AW'($urandom);
      end
      if (!d_read && !d_write && d_cool == 0 && $urandom_range(0, 2) == 0) begin
        r       = int'($urandom_range(0, 9));
        d_write = (r < 4);
        d_read  = (r >= 4) || (r == 0);
        d_addr  = AW'($urandom);
        d_wdata = rand128();
      end
      at_neg();
      tick();
      if (proc_reset) begin
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_cool = 0; d_cool = 0;
      end else begin
        if (e_i_ready) begin
          i_read = 1'b0;
          i_cool = 1;
        end else if (i_cool > 0) begin
          i_cool--;
        end
        if (e_d_ready) begin
          d_read = 1'b0; d_write = 1'b0;
          d_cool = 1;
        end else if (d_cool > 0) begin
          d_cool--;
        end
      end
    end
    proc_reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
